// File: rtl/udp_tx_packetizer.sv
// Streams a block of SRAM words out as big-endian UDP payload bytes, split into packets.
// Define UDP_TX_SEQ_HDR_EN to prefix every packet with a 16-bit sequence number.
//
// state   | meaning
// IDLE    | waiting for i_start
// HDR_HI  | presenting sequence number high byte
// HDR_LO  | presenting sequence number low byte
// RD_WAIT | SRAM read strobes active, counting read wait cycles
// SEND_HI | presenting word[15:8]
// SEND_LO | presenting word[7:0]
// DONE    | one-cycle completion pulse
module udp_tx_packetizer #(
    parameter int PKT_WORDS = 256,
    parameter int READ_WAIT = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [19:0] i_base_addr,
    input  logic [19:0] i_num_words,
    output logic        o_busy,
    output logic        o_done,
    output logic [19:0] o_SRAM_ADDR,
    input  logic [15:0] i_SRAM_DQ,
    output logic        o_SRAM_CE_N,
    output logic        o_SRAM_OE_N,
    output logic        o_SRAM_WE_N,
    output logic        o_SRAM_LB_N,
    output logic        o_SRAM_UB_N,
    output logic [7:0]  udp_tx_data,
    output logic        udp_tx_valid,
    input  logic        udp_tx_ready,
    output logic        udp_tx_last
);

`ifdef UDP_TX_SEQ_HDR_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    localparam logic [3:0]  WAIT_LOAD = 4'(READ_WAIT - 1);
    localparam logic [10:0] PKT_LAST  = 11'(PKT_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        RD_WAIT,
        SEND_HI,
        SEND_LO,
        DONE
    } state_t;

    state_t      state;
    logic [19:0] addr;
    logic [19:0] remaining;
    logic [10:0] pkt_cnt;
    logic [3:0]  wait_cnt;
    logic [7:0]  lo_byte;
    logic [15:0] seq;
    logic        ce_n;
    logic        oe_n;
    logic        bs_n;

    logic        accept;
    logic        pkt_word_last;
    logic        xfer_word_last;
    logic [15:0] seq_next;

    assign accept         = udp_tx_valid && udp_tx_ready;
    assign pkt_word_last  = (pkt_cnt == PKT_LAST);
    assign xfer_word_last = (remaining == 20'd1);
    assign seq_next       = seq + 16'd1;

    assign o_SRAM_ADDR = addr;
    assign o_SRAM_CE_N = ce_n;
    assign o_SRAM_OE_N = oe_n;
    assign o_SRAM_WE_N = 1'b1;
    assign o_SRAM_LB_N = bs_n;
    assign o_SRAM_UB_N = bs_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            addr         <= '0;
            remaining    <= '0;
            pkt_cnt      <= '0;
            wait_cnt     <= '0;
            lo_byte      <= '0;
            seq          <= '0;
            ce_n         <= 1'b1;
            oe_n         <= 1'b1;
            bs_n         <= 1'b1;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            udp_tx_data  <= '0;
            udp_tx_valid <= 1'b0;
            udp_tx_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        addr      <= i_base_addr;
                        remaining <= i_num_words;
                        pkt_cnt   <= '0;
                        o_busy    <= 1'b1;
                        if (i_num_words == 20'd0) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else if (HDR_EN) begin
                            state        <= HDR_HI;
                            udp_tx_valid <= 1'b1;
                            udp_tx_data  <= seq[15:8];
                            udp_tx_last  <= 1'b0;
                        end else begin
                            state    <= RD_WAIT;
                            wait_cnt <= WAIT_LOAD;
                            ce_n     <= 1'b0;
                            oe_n     <= 1'b0;
                            bs_n     <= 1'b0;
                        end
                    end
                end

                HDR_HI: begin
                    if (accept) begin
                        udp_tx_data <= seq[7:0];
                        state       <= HDR_LO;
                    end
                end

                HDR_LO: begin
                    if (accept) begin
                        udp_tx_valid <= 1'b0;
                        state        <= RD_WAIT;
                        wait_cnt     <= WAIT_LOAD;
                        ce_n         <= 1'b0;
                        oe_n         <= 1'b0;
                        bs_n         <= 1'b0;
                    end
                end

                // Word is captured on the final edge of the read window.
                RD_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        udp_tx_data  <= i_SRAM_DQ[15:8];
                        lo_byte      <= i_SRAM_DQ[7:0];
                        udp_tx_valid <= 1'b1;
                        udp_tx_last  <= 1'b0;
                        ce_n         <= 1'b1;
                        oe_n         <= 1'b1;
                        bs_n         <= 1'b1;
                        state        <= SEND_HI;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                SEND_HI: begin
                    if (accept) begin
                        udp_tx_data <= lo_byte;
                        udp_tx_last <= pkt_word_last || xfer_word_last;
                        state       <= SEND_LO;
                    end
                end

                SEND_LO: begin
                    if (accept) begin
                        udp_tx_valid <= 1'b0;
                        udp_tx_last  <= 1'b0;
                        addr         <= addr + 20'd1;
                        remaining    <= remaining - 20'd1;
                        if (udp_tx_last) begin
                            pkt_cnt <= '0;
                            if (HDR_EN) seq <= seq_next;
                        end else begin
                            pkt_cnt <= pkt_cnt + 11'd1;
                        end
                        if (xfer_word_last) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else if (HDR_EN && udp_tx_last) begin
                            state        <= HDR_HI;
                            udp_tx_valid <= 1'b1;
                            udp_tx_data  <= seq_next[15:8];
                        end else begin
                            state    <= RD_WAIT;
                            wait_cnt <= WAIT_LOAD;
                            ce_n     <= 1'b0;
                            oe_n     <= 1'b0;
                            bs_n     <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Randomized bench for udp_tx_packetizer: a byte-list model of each transfer is compared
// against the bytes accepted on the stream port, plus SRAM strobe, handshake and timing checks.
module tb_udp_tx_packetizer;

    localparam int PKT_WORDS = 3;
    localparam int READ_WAIT = 2;
`ifdef UDP_TX_SEQ_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [19:0] base_addr = '0;
    logic [19:0] num_words = '0;
    logic        busy, done;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq;
    logic        ce_n, oe_n, we_n, lb_n, ub_n;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        tx_last;

    udp_tx_packetizer #(.PKT_WORDS(PKT_WORDS), .READ_WAIT(READ_WAIT)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_base_addr  (base_addr),
        .i_num_words  (num_words),
        .o_busy       (busy),
        .o_done       (done),
        .o_SRAM_ADDR  (sram_addr),
        .i_SRAM_DQ    (sram_dq),
        .o_SRAM_CE_N  (ce_n),
        .o_SRAM_OE_N  (oe_n),
        .o_SRAM_WE_N  (we_n),
        .o_SRAM_LB_N  (lb_n),
        .o_SRAM_UB_N  (ub_n),
        .udp_tx_data  (tx_data),
        .udp_tx_valid (tx_valid),
        .udp_tx_ready (tx_ready),
        .udp_tx_last  (tx_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SRAM contents: mode 0 gives the 0x1213,0x1415,... pattern from address 0x10 upward
    int          mem_mode = 0;
    logic [31:0] mem_key  = '0;

    function automatic logic [15:0] mem_word(input logic [19:0] a, input int mode, input logic [31:0] key);
        logic [7:0]  h;
        logic [31:0] t;
        if (mode == 0) begin
            h = 8'(2 * int'(a[7:0]) - 14);
            return {h, 8'(h + 8'd1)};
        end
        t = ({12'd0, a} * 32'h9E3779B1) ^ key;
        return t[31:16] ^ t[15:0];
    endfunction

    assign sram_dq = oe_n ? 16'hDEAD : mem_word(sram_addr, mem_mode, mem_key);

    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            2:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
        endcase
    end

    int          cyc = 0;
    logic [8:0]  got[$];
    logic [19:0] rd_addrs[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          first_valid_cyc = 0;
    bit          prev_stall = 0;
    logic [8:0]  prev_bits = '0;
    logic        prev_ce_n = 1'b1;
    logic [19:0] prev_addr = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_stall = 0;
            prev_ce_n  = 1'b1;
        end else begin
            check("we_n_high", we_n, 1);
            check("strobes_together", {oe_n, lb_n, ub_n}, {3{ce_n}});
            if (!ce_n) check("read_only_when_busy", busy, 1);
            if (!ce_n && !prev_ce_n) check("addr_stable", sram_addr, prev_addr);
            if (prev_stall) begin
                check("valid_held", tx_valid, 1);
                check("data_held", {tx_last, tx_data}, prev_bits);
            end
            if (!ce_n && prev_ce_n) rd_addrs.push_back(sram_addr);
            if (tx_valid && first_valid_cyc == 0) first_valid_cyc = cyc;
            if (tx_valid && tx_ready) got.push_back({tx_last, tx_data});
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_bits  = {tx_last, tx_data};
            prev_ce_n  = ce_n;
            prev_addr  = sram_addr;
        end
    end

    logic [8:0]  exp_q[$];
    logic [19:0] exp_addr[$];
    logic [15:0] exp_seq = '0;

    task automatic build_model(input logic [19:0] base, input int n);
        logic [19:0] a;
        logic [15:0] d;
        bit          pkt_end;
        exp_q.delete();
        exp_addr.delete();
        for (int w = 0; w < n; w++) begin
            a       = base + 20'(w);
            d       = mem_word(a, mem_mode, mem_key);
            pkt_end = (w % PKT_WORDS == PKT_WORDS - 1) || (w == n - 1);
            if (HDR && (w % PKT_WORDS == 0)) begin
                exp_q.push_back({1'b0, exp_seq[15:8]});
                exp_q.push_back({1'b0, exp_seq[7:0]});
            end
            exp_addr.push_back(a);
            exp_q.push_back({1'b0, d[15:8]});
            exp_q.push_back({pkt_end, d[7:0]});
            if (pkt_end) exp_seq++;
        end
    endtask

    // A second i_start is always held into the cycle after the accepted one; it must be ignored.
    task automatic run_xfer(input string tag, input logic [19:0] base, input int n,
                            input int rmode, input bit poke);
        int start_cyc;
        int budget;
        int npk;
        int exp_done;
        build_model(base, n);
        rdy_mode = rmode;
        @(posedge clk);
        #2;
        got.delete();
        rd_addrs.delete();
        done_cnt        = 0;
        first_valid_cyc = 0;
        start     = 1'b1;
        base_addr = base;
        num_words = 20'(n);
        @(posedge clk);
        start_cyc = cyc;
        #2;
        base_addr = 20'($urandom);
        num_words = 20'($urandom_range(1, 40));
        @(posedge clk);
        #2;
        start  = 1'b0;
        budget = 1;
        while (done_cnt == 0 && budget < 2000) begin
            @(posedge clk);
            budget++;
            if (poke && budget == 5) begin
                #2 start = 1'b1;
                @(posedge clk);
                budget++;
                #2 start = 1'b0;
            end
        end
        check({tag, "_timeout"}, budget < 2000, 1);
        repeat (6) @(posedge clk);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_byte_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size()) check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
        check({tag, "_read_count"}, rd_addrs.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size(); i++)
            if (i < rd_addrs.size()) check($sformatf("%s_addr%0d", tag, i), rd_addrs[i], exp_addr[i]);
        if (n == 0) check({tag, "_no_valid"}, first_valid_cyc, 0);
        if (rmode == 0) begin
            npk      = (n + PKT_WORDS - 1) / PKT_WORDS;
            exp_done = n * (READ_WAIT + 2) + (HDR ? 2 * npk : 0) + 1;
            check({tag, "_done_latency"}, done_cyc - start_cyc, exp_done);
            if (n > 0)
                check({tag, "_valid_latency"}, first_valid_cyc - start_cyc, HDR ? 1 : READ_WAIT + 1);
        end
    endtask

    initial begin
        int budget;
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", tx_valid, 0);
        check("rst_last", tx_last, 0);
        check("rst_data", tx_data, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_strobes", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'h1F);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        mem_mode = 0;
        run_xfer("basic", 20'h00010, 3, 0, 0);
        mem_mode = 1;
        mem_key  = $urandom;
        run_xfer("multi_pkt", 20'($urandom), 5, 0, 0);
        run_xfer("toggle", 20'($urandom), 2, 1, 0);
        run_xfer("zero", 20'($urandom), 0, 0, 0);
        run_xfer("wrap", 20'hFFFFF, 2, 0, 0);
        run_xfer("exact", 20'($urandom), 6, 2, 1);
        for (int k = 0; k < 8; k++)
            run_xfer($sformatf("rand%0d", k), 20'($urandom), int'($urandom_range(1, 10)),
                     int'($urandom_range(0, 2)), k[0]);

        // Abort mid-packet with valid stalled high.
        rdy_mode = 3;
        @(posedge clk);
        #2;
        start     = 1'b1;
        base_addr = 20'h00300;
        num_words = 20'd4;
        @(posedge clk);
        #2 start = 1'b0;
        budget = 0;
        while (!tx_valid && budget < 50) begin
            @(posedge clk);
            #2;
            budget++;
        end
        check("pre_rst_valid", tx_valid, 1);
        done_cnt = 0;
        #1 rst_n = 1'b0;
        #1;
        check("abort_valid", tx_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_last", tx_last, 0);
        check("abort_ce_n", ce_n, 1);
        check("abort_addr", sram_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        check("abort_no_done", done_cnt, 0);
        exp_seq = '0;
        run_xfer("post_rst_a", 20'($urandom), 1, 0, 0);
        run_xfer("post_rst_b", 20'($urandom), 1, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
